// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 slave: synchronizes SCLK/COPI/nCS into clk, shifts 16-bit
// frames MSB-first and commits valid writes into five 8-bit control registers.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam int NUM_REGS = 5;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_dly_q, ncs_dly_q;
  logic [15:0]            shift_q, shift_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [7:0]             regs_q [NUM_REGS];
  logic [7:0]             regs_d [NUM_REGS];
  logic                   strobe_q, strobe_d;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise, frame_ok;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q;
  assign ncs_rise  = ncs_s & ~ncs_dly_q;
  assign frame_ok  = (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= 7'd4);

  // nCS sync/delay flops reset high so a still-low pin at release reads as a new frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
      shift_q     <= '0;
      cnt_q       <= '0;
      strobe_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_dly_q  <= sclk_s;
      ncs_dly_q   <= ncs_s;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      strobe_q    <= strobe_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // A frame end takes priority over a coincident SCLK rise, so the commit sees the old count.
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

    if (ncs_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (ncs_rise) begin
      if (frame_ok) begin
        strobe_d = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
        end
      end
    end else if (!ncs_s && sclk_rise) begin
      shift_d = {shift_q[14:0], copi_s};
      cnt_d   = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_strobe       = strobe_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: directed and random SPI frames against a
// frame-level register model, compared every cycle plus literal spot checks.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] m_regs [5];
  logic       exp_strobe = 1'b0;

  localparam int HALF = 4;

  spi_peripheral #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare of every output against the model, away from the active edge.
  always @(negedge clk) begin
    check("reg0", en_reg_out_7_0,  m_regs[0]);
    check("reg1", en_reg_out_15_8, m_regs[1]);
    check("reg2", en_reg_pwm_7_0,  m_regs[2]);
    check("reg3", en_reg_pwm_15_8, m_regs[3]);
    check("reg4", pwm_duty_cycle,  m_regs[4]);
    check("wr_strobe", wr_strobe, exp_strobe);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_frame();
    ncs = 1'b0;
    wait_cycles(HALF);
  endtask

  task automatic send_bits(input int nbits, input logic [16:0] val);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = val[i];
      wait_cycles(HALF);
      sclk = 1'b1;
      wait_cycles(HALF);
      sclk = 1'b0;
    end
    wait_cycles(HALF);
  endtask

  // Raises nCS and applies the frame rule to the model at the 3rd clk edge after the raise.
  task automatic end_frame(input int nbits, input logic [15:0] val);
    logic commit;
    int   seen;
    commit = (nbits == 16) && val[15] && (val[14:8] <= 7'd4);
    ncs = 1'b1;
    seen = 0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      if (e == 3 && commit) begin
        m_regs[val[10:8]] = val[7:0];
        exp_strobe = 1'b1;
      end else begin
        exp_strobe = 1'b0;
      end
      #1;
      if (wr_strobe && seen == 0) seen = e;
    end
    #1;
    if (commit) check("commit_latency", seen, 3);
    else        check("no_commit_strobe", seen, 0);
    $display("[TB] frame bits=%0d val=%h commit=%0d", nbits, val, commit);
  endtask

  task automatic frame(input int nbits, input logic [16:0] val);
    start_frame();
    send_bits(nbits, val);
    end_frame(nbits, val[15:0]);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    wait_cycles(3);
    check("reset_duty", pwm_duty_cycle, 8'h00);
    check("reset_strobe", wr_strobe, 0);
    rst_n = 1'b1;
    wait_cycles(4);

    frame(16, 17'h080F0);
    check("lit_out_7_0", en_reg_out_7_0, 8'hF0);
    check("lit_out_15_8_zero", en_reg_out_15_8, 8'h00);

    frame(16, 17'h08480);
    frame(16, 17'h082FF);
    frame(16, 17'h08101);
    check("lit_duty", pwm_duty_cycle, 8'h80);
    check("lit_pwm_7_0", en_reg_pwm_7_0, 8'hFF);
    check("lit_out_15_8", en_reg_out_15_8, 8'h01);

    frame(16, 17'h000AA);
    frame(16, 17'h08555);
    frame(15, 17'h080F0 >> 1);
    frame(17, 17'h180F0);
    frame(17, 17'h080AA);
    check("lit_after_discards_out", en_reg_out_7_0, 8'hF0);
    check("lit_after_discards_duty", pwm_duty_cycle, 8'h80);

    for (int n = 0; n < 30; n++) begin
      int nbits;
      logic [16:0] v;
      case ($urandom_range(0, 5))
        0:       nbits = 15;
        1:       nbits = 17;
        default: nbits = 16;
      endcase
      v = 17'($urandom);
      v[14:8] = 7'($urandom_range(0, 6));
      if ($urandom_range(0, 3) != 0) v[15] = 1'b1;
      frame(nbits, v);
    end

    frame(16, 17'h08155);
    check("lit_before_reset", en_reg_out_15_8, 8'h55);

    start_frame();
    send_bits(8, 17'h00084);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    exp_strobe = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(HALF);
    send_bits(8, 17'h00033);
    end_frame(8, 16'h0033);
    check("lit_reset_out_15_8", en_reg_out_15_8, 8'h00);
    check("lit_reset_duty", pwm_duty_cycle, 8'h00);

    frame(16, 17'h08433);
    check("lit_duty_33", pwm_duty_cycle, 8'h33);

    wait_cycles(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

Write-only SPI mode-0 slave feeding the PWM/output stage of `tt_um_uwasic_onboarding_julie_yang`. Samples external SCLK/COPI/nCS pins (from `ui_in`) through synchronizers in the `clk` domain. Decodes 16-bit write frames into five 8-bit control registers that drive output enables, PWM enables and PWM duty cycle.

## Interface
- `SYNC_STAGES`, 2, flip-flop depth of each input synchronizer; legal values ≥ 2.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock pin (`ui_in[0]`), asynchronous to `clk`.
- `copi`  in  1  SPI data in (`ui_in[1]`), asynchronous.
- `ncs`  in  1  SPI chip select, active low (`ui_in[2]`), asynchronous.
- `en_reg_out_7_0`  out  8  register 0x00.
- `en_reg_out_15_8`  out  8  register 0x01.
- `en_reg_pwm_7_0`  out  8  register 0x02.
- `en_reg_pwm_15_8`  out  8  register 0x03.
- `pwm_duty_cycle`  out  8  register 0x04.
- `wr_strobe`  out  1  one-cycle pulse on each committed register write.

## Operation
- Reset (async, `rst_n`=0): all five registers 0x00, `wr_strobe` 0, shift register 0, bit counter 0.
- Sync flops for `ncs` reset to 1; sync flops for `sclk`/`copi` reset to 0.
- Edge detect on synchronized signals uses one extra delay flop per signal.
- Frame start (nCS falling edge): bit counter cleared, shift register cleared.
- While synced nCS = 0, each synced SCLK rising edge:
  - shifts synced COPI into shift register LSB (MSB-first on wire);
  - increments bit counter, saturating at 17.
- SCLK falling edges are ignored. SCLK edges while synced nCS = 1 are ignored.
- Frame end (nCS rising edge): commit iff all hold:
  - counter == 16 exactly;
  - bit 15 (R/W) == 1;
  - bits 14:8 (address) ≤ 0x04.
- Commit writes bits 7:0 into the addressed register and pulses `wr_strobe` for one cycle.
- Otherwise the frame is discarded: no register change, no strobe.
- Read frames (R/W = 0) are always discarded; the block has no CIPO output.
- Frames with more than 16 bits saturate the counter and are discarded.
- Registers hold their value until the next commit to the same address or reset.

## Timing
- Pin-to-use latency: a pin change sampled at clk edge k appears at sync output at edge k+SYNC_STAGES−1.
  - Edge-detect fires in the following cycle.
  - Action (shift, clear, commit) takes effect at edge k+SYNC_STAGES.
- Commit latency: with SYNC_STAGES = 2, a register output changes, and `wr_strobe` rises, at the 3rd clk edge counting the edge that first samples nCS high.
- `wr_strobe` is high for exactly one clk cycle per committed frame.
- SCLK high time and low time must each be ≥ SYNC_STAGES+1 clk periods.
- nCS setup before the first SCLK rise, and hold after the last, must each be ≥ SYNC_STAGES+1 clk periods.
- Back-to-back frames: nCS high time ≥ SYNC_STAGES+1 clk periods. Each frame commits independently.
- Simultaneous synced nCS rise and SCLK rise in the same cycle: the SCLK edge is ignored and the commit uses the existing count.
- Reset asserted mid-frame: the partial frame is lost and registers return to 0x00.
  - If `ncs` is still low at reset release, the sync reset value (1) produces a falling edge and a new frame starts mid-stream.
  - That frame has count ≠ 16 and is discarded.

## Test plan
- Write frame 0x80F0 (addr 0x00, data 0xF0) → `en_reg_out_7_0` = 0xF0 and one `wr_strobe` pulse; all other registers stay 0x00.
- Write frames 0x84_80, 0x82_FF, 0x81_01 → duty = 0x80, `en_reg_pwm_7_0` = 0xFF, `en_reg_out_15_8` = 0x01. Verify back-to-back frames with minimum nCS gap.
- Read frame 0x00AA, then invalid-address write 0x8555 (addr 0x05) → no register change and no `wr_strobe`.
- 15-bit frame (0x80F0 truncated) and 17-bit frame → discarded, registers unchanged.
- Drop `rst_n` after 8 bits of 0x8433 while nCS is held low, then release mid-frame → all registers 0x00 and no commit. A following valid 0x8433 → duty = 0x33.
- Commit timing: measure clk edges from the first edge sampling nCS high to the register change → exactly 3 with SYNC_STAGES = 2.
